// File: rtl/data_mem_arbiter.sv
// -----------------------------------------------------------------------------
// data_mem_arbiter
//
// Purpose:
//   Shares the single-port data memory between the pipeline MEM stage (CPU) and
//   a debug/loader port (DBG). The CPU owns the memory by default. A pending
//   DBG request gets a one-cycle word-access slot either when the CPU is idle
//   or once it has been starved for MAX_WAIT cycles. When the slot collides
//   with a CPU access, the pipeline is stalled and the CPU access retries in
//   the following cycle.
//
// Parameters:
//   MAX_WAIT  cycles a pending DBG request may be starved (0 = DBG always wins)
//
// Optional feature (macro DMEM_ARB_STATS_EN):
//   Adds output Stat_ConflictCount[15:0], counting DBG-slot cycles in which
//   the CPU also wanted the memory. Saturates at 16'hFFFF and clears on reset.
//   With the macro undefined the port and its counter are absent.
//
// Ports:
//   Clk, Reset_n          clock, synchronous active-low reset
//   Cpu_*  (in)           EX/MEM request: address, store data, read/write,
//                         halfword/byte size controls
//   Cpu_ReadData (out)    combinational pass-through of Mem_ReadData
//   Cpu_Stall (out)       hold EX/MEM and earlier stages this cycle
//   Dbg_Req/Write/Address/WriteData (in)  debug word request, held until ack
//   Dbg_Ack (out)         one-cycle completion pulse
//   Dbg_ReadData (out)    registered read data, held until the next ack
//   Mem_* (out)           request to DataMemory
//   Mem_ReadData (in)     combinational read data from DataMemory
// -----------------------------------------------------------------------------
module data_mem_arbiter #(
   parameter int MAX_WAIT = 4
) (
   input  logic        Clk,
   input  logic        Reset_n,
   input  logic [31:0] Cpu_Address,
   input  logic [31:0] Cpu_WriteData,
   input  logic        Cpu_MemWrite,
   input  logic        Cpu_MemRead,
   input  logic        Cpu_HalfControl,
   input  logic        Cpu_ByteControl,
   output logic [31:0] Cpu_ReadData,
   output logic        Cpu_Stall,
   input  logic        Dbg_Req,
   input  logic        Dbg_Write,
   input  logic [31:0] Dbg_Address,
   input  logic [31:0] Dbg_WriteData,
   output logic        Dbg_Ack,
   output logic [31:0] Dbg_ReadData,
   output logic [31:0] Mem_Address,
   output logic [31:0] Mem_WriteData,
   output logic        Mem_MemWrite,
   output logic        Mem_MemRead,
   output logic        Mem_HalfControl,
   output logic        Mem_ByteControl,
   input  logic [31:0] Mem_ReadData
`ifdef DMEM_ARB_STATS_EN
   ,
   output logic [15:0] Stat_ConflictCount
`endif
);

   // A zero-width counter is illegal, so MAX_WAIT=0 still gets one bit; the
   // compare against WAIT_MAX is then always true and the counter never moves.
   localparam int              WCW      = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
   localparam logic [WCW-1:0]  WAIT_MAX = WCW'(MAX_WAIT);

   typedef enum logic [1:0] {
      S_CPU = 2'd0,
      S_DBG = 2'd1,
      S_ACK = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [WCW-1:0]  wait_cnt_q, wait_cnt_d;
   logic            dbg_ack_q, dbg_ack_d;
   logic [31:0]     dbg_rdata_q, dbg_rdata_d;

   logic            cpu_acc;
   logic            grant_dbg;

   assign cpu_acc   = Cpu_MemRead | Cpu_MemWrite;
   // Only evaluated in the CPU state: DBG goes in when the CPU leaves a hole
   // or when the request has been starved long enough.
   assign grant_dbg = Dbg_Req & (~cpu_acc | (wait_cnt_q == WAIT_MAX));

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         state_q     <= S_CPU;
         wait_cnt_q  <= '0;
         dbg_ack_q   <= 1'b0;
         dbg_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         dbg_ack_q   <= dbg_ack_d;
         dbg_rdata_q <= dbg_rdata_d;
      end
   end

   // ---------------------------------------------------------- next-state comb
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_CPU:   state_d = grant_dbg ? S_DBG : S_CPU;
         S_DBG:   state_d = S_ACK;
         // Dbg_Req is ignored here; the requester drops it on seeing the ack.
         S_ACK:   state_d = S_CPU;
         default: state_d = S_CPU;
      endcase
   end

   // ------------------------------------------------- wait counter / DBG data
   always_comb begin
      wait_cnt_d  = wait_cnt_q;
      dbg_ack_d   = (state_q == S_DBG);
      dbg_rdata_d = dbg_rdata_q;

      if (state_q == S_CPU) begin
         // Cleared both when the slot is granted and when the request is
         // withdrawn, so a new request always starts a fresh wait window.
         if (!Dbg_Req || grant_dbg) begin
            wait_cnt_d = '0;
         end else if (wait_cnt_q != WAIT_MAX) begin
            wait_cnt_d = wait_cnt_q + WCW'(1);
         end
      end

      // Writes leave the captured read data untouched.
      if (state_q == S_DBG && !Dbg_Write) begin
         dbg_rdata_d = Mem_ReadData;
      end
   end

   // -------------------------------------------------------------- output comb
   always_comb begin
      Mem_Address     = Cpu_Address;
      Mem_WriteData   = Cpu_WriteData;
      Mem_MemWrite    = Cpu_MemWrite;
      Mem_MemRead     = Cpu_MemRead;
      Mem_HalfControl = Cpu_HalfControl;
      Mem_ByteControl = Cpu_ByteControl;
      Cpu_Stall       = 1'b0;

      if (state_q == S_DBG) begin
         // Debug accesses are always aligned full words.
         Mem_Address     = {Dbg_Address[31:2], 2'b00};
         Mem_WriteData   = Dbg_WriteData;
         Mem_MemWrite    = Dbg_Write;
         Mem_MemRead     = ~Dbg_Write;
         Mem_HalfControl = 1'b0;
         Mem_ByteControl = 1'b0;
         Cpu_Stall       = cpu_acc;
      end

      // Strobes are gated while reset is held so an aborted DBG slot (or a
      // stray CPU store) never reaches the memory.
      if (!Reset_n) begin
         Mem_MemWrite = 1'b0;
         Mem_MemRead  = 1'b0;
         Cpu_Stall    = 1'b0;
      end
   end

   assign Cpu_ReadData = Mem_ReadData;
   assign Dbg_Ack      = dbg_ack_q;
   assign Dbg_ReadData = dbg_rdata_q;

`ifdef DMEM_ARB_STATS_EN
   // ------------------------------------------------------ conflict statistics
   logic [15:0] conflict_cnt_q, conflict_cnt_d;

   always_comb begin
      conflict_cnt_d = conflict_cnt_q;
      if (state_q == S_DBG && cpu_acc && conflict_cnt_q != 16'hFFFF) begin
         conflict_cnt_d = conflict_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         conflict_cnt_q <= '0;
      end else begin
         conflict_cnt_q <= conflict_cnt_d;
      end
   end

   assign Stat_ConflictCount = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_data_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_data_mem_arbiter
//
// Purpose:
//   Directed bench for data_mem_arbiter. Two instances share the same stimulus:
//   u_dut4 (MAX_WAIT=4) carries most scenarios, u_dut0 (MAX_WAIT=0) the
//   "debug always wins" byte-store scenario. Each instance drives its own
//   word-organised DataMemory model with byte/halfword write lanes.
//   Stat_ConflictCount is exercised when DMEM_ARB_STATS_EN is defined.
//
// Ports: none (top-level bench).
// -----------------------------------------------------------------------------
module tb_data_mem_arbiter;

   logic        clk;
   logic        rst_n;
   logic [31:0] cpu_address;
   logic [31:0] cpu_wdata;
   logic        cpu_mw;
   logic        cpu_mr;
   logic        cpu_half;
   logic        cpu_byte;
   logic        dbg_req;
   logic        dbg_write;
   logic [31:0] dbg_address;
   logic [31:0] dbg_wdata;

   logic [31:0] cpu_rdata4, dbg_rdata4, mem_addr4, mem_wdata4, mem_rdata4;
   logic        cpu_stall4, dbg_ack4, mem_mw4, mem_mr4, mem_half4, mem_byte4;
   logic [31:0] cpu_rdata0, dbg_rdata0, mem_addr0, mem_wdata0, mem_rdata0;
   logic        cpu_stall0, dbg_ack0, mem_mw0, mem_mr0, mem_half0, mem_byte0;
`ifdef DMEM_ARB_STATS_EN
   logic [15:0] stat4, stat0;
`endif

   logic [31:0] mem4 [256];
   logic [31:0] mem0 [256];

   int vectors = 0;
   int errors  = 0;

   data_mem_arbiter #(.MAX_WAIT(4)) u_dut4 (
      .Clk(clk), .Reset_n(rst_n),
      .Cpu_Address(cpu_address), .Cpu_WriteData(cpu_wdata),
      .Cpu_MemWrite(cpu_mw), .Cpu_MemRead(cpu_mr),
      .Cpu_HalfControl(cpu_half), .Cpu_ByteControl(cpu_byte),
      .Cpu_ReadData(cpu_rdata4), .Cpu_Stall(cpu_stall4),
      .Dbg_Req(dbg_req), .Dbg_Write(dbg_write),
      .Dbg_Address(dbg_address), .Dbg_WriteData(dbg_wdata),
      .Dbg_Ack(dbg_ack4), .Dbg_ReadData(dbg_rdata4),
      .Mem_Address(mem_addr4), .Mem_WriteData(mem_wdata4),
      .Mem_MemWrite(mem_mw4), .Mem_MemRead(mem_mr4),
      .Mem_HalfControl(mem_half4), .Mem_ByteControl(mem_byte4),
      .Mem_ReadData(mem_rdata4)
`ifdef DMEM_ARB_STATS_EN
      , .Stat_ConflictCount(stat4)
`endif
   );

   data_mem_arbiter #(.MAX_WAIT(0)) u_dut0 (
      .Clk(clk), .Reset_n(rst_n),
      .Cpu_Address(cpu_address), .Cpu_WriteData(cpu_wdata),
      .Cpu_MemWrite(cpu_mw), .Cpu_MemRead(cpu_mr),
      .Cpu_HalfControl(cpu_half), .Cpu_ByteControl(cpu_byte),
      .Cpu_ReadData(cpu_rdata0), .Cpu_Stall(cpu_stall0),
      .Dbg_Req(dbg_req), .Dbg_Write(dbg_write),
      .Dbg_Address(dbg_address), .Dbg_WriteData(dbg_wdata),
      .Dbg_Ack(dbg_ack0), .Dbg_ReadData(dbg_rdata0),
      .Mem_Address(mem_addr0), .Mem_WriteData(mem_wdata0),
      .Mem_MemWrite(mem_mw0), .Mem_MemRead(mem_mr0),
      .Mem_HalfControl(mem_half0), .Mem_ByteControl(mem_byte0),
      .Mem_ReadData(mem_rdata0)
`ifdef DMEM_ARB_STATS_EN
      , .Stat_ConflictCount(stat0)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // DataMemory model: little-endian byte lanes, store data right-aligned.
   function automatic logic [31:0] merge(input logic [31:0] old_w,
                                         input logic [31:0] wd,
                                         input logic [1:0]  lane,
                                         input logic        half,
                                         input logic        byte_en);
      logic [31:0] r;
      r = old_w;
      if (byte_en)   r[lane*8 +: 8]     = wd[7:0];
      else if (half) r[lane[1]*16 +: 16] = wd[15:0];
      else           r = wd;
      return r;
   endfunction

   assign mem_rdata4 = mem4[mem_addr4[9:2]];
   assign mem_rdata0 = mem0[mem_addr0[9:2]];

   always_ff @(posedge clk) begin
      if (mem_mw4)
         mem4[mem_addr4[9:2]] <= merge(mem4[mem_addr4[9:2]], mem_wdata4,
                                       mem_addr4[1:0], mem_half4, mem_byte4);
      if (mem_mw0)
         mem0[mem_addr0[9:2]] <= merge(mem0[mem_addr0[9:2]], mem_wdata0,
                                       mem_addr0[1:0], mem_half0, mem_byte0);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge; inputs are driven here and
   // outputs are checked after a further settle delay.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0; cpu_address = '0; cpu_wdata = '0; cpu_mw = 1'b1; cpu_mr = 1'b0;
      cpu_half = 1'b0; cpu_byte = 1'b0; dbg_req = 1'b1; dbg_write = 1'b0;
      dbg_address = '0; dbg_wdata = '0;

      // 1: reset held two cycles with a CPU store and a DBG request pending
      for (int i = 0; i < 2; i++) begin
         step(); #2;
         chk("rst_mem_write", 32'(mem_mw4), 32'd0);
         chk("rst_stall",     32'(cpu_stall4), 32'd0);
         chk("rst_ack",       32'(dbg_ack4), 32'd0);
         chk("rst_dbg_rdata", dbg_rdata4, 32'h0);
      end
      step(); rst_n = 1'b1; cpu_mw = 1'b0; dbg_req = 1'b0; #2;

      // 2: idle CPU, DBG write 0xDEADBEEF @0x40
      step(); dbg_req = 1'b1; dbg_write = 1'b1; dbg_address = 32'h40;
      dbg_wdata = 32'hDEADBEEF; #2;
      chk("t2_req_stall", 32'(cpu_stall4), 32'd0);
      step(); #2;
      chk("t2_dbg_addr",  mem_addr4, 32'h40);
      chk("t2_dbg_write", 32'(mem_mw4), 32'd1);
      chk("t2_dbg_read",  32'(mem_mr4), 32'd0);
      chk("t2_no_ack",    32'(dbg_ack4), 32'd0);
      step(); #2;
      chk("t2_ack",       32'(dbg_ack4), 32'd1);
      chk("t2_rdata_kept", dbg_rdata4, 32'h0);
      dbg_req = 1'b0;
      step(); cpu_mr = 1'b1; cpu_address = 32'h40; #2;
      chk("t2_ack_pulse", 32'(dbg_ack4), 32'd0);
      chk("t2_cpu_lw",    cpu_rdata4, 32'hDEADBEEF);

      // 3: CPU loads every cycle, DBG read @0x40 waits MAX_WAIT cycles
      step(); cpu_address = 32'h44; dbg_req = 1'b1; dbg_write = 1'b0;
      dbg_address = 32'h40; #2;
      chk("t3_wait_stall0", 32'(cpu_stall4), 32'd0);
      for (int i = 1; i <= 4; i++) begin
         step(); #2;
         chk("t3_wait_stall", 32'(cpu_stall4), 32'd0);
      end
      step(); #2;
      chk("t3_dbg_stall", 32'(cpu_stall4), 32'd1);
      chk("t3_dbg_addr",  mem_addr4, 32'h40);
      chk("t3_dbg_read",  32'(mem_mr4), 32'd1);
      step(); #2;
      chk("t3_ack",       32'(dbg_ack4), 32'd1);
      chk("t3_rdata",     dbg_rdata4, 32'hDEADBEEF);
      chk("t3_cpu_retry", 32'(cpu_stall4), 32'd0);
      chk("t3_cpu_addr",  mem_addr4, 32'h44);
      dbg_req = 1'b0;

      // 3b: withdrawn request restarts the wait window
      step(); dbg_req = 1'b1; #2;
      step(); #2;
      step(); dbg_req = 1'b0; #2;
      step(); dbg_req = 1'b1; #2;
      chk("t3b_stall_d0", 32'(cpu_stall4), 32'd0);
      for (int i = 1; i <= 4; i++) begin
         step(); #2;
         chk("t3b_wait_stall", 32'(cpu_stall4), 32'd0);
      end
      step(); #2;
      chk("t3b_dbg_stall", 32'(cpu_stall4), 32'd1);
      step(); #2;
      chk("t3b_ack", 32'(dbg_ack4), 32'd1);
      dbg_req = 1'b0;

      // 4: DBG read @0x43 with CPU idle; size controls forced to word
      step(); cpu_mr = 1'b0; cpu_half = 1'b1; cpu_byte = 1'b1;
      dbg_req = 1'b1; dbg_address = 32'h43; #2;
      chk("t4_req_stall", 32'(cpu_stall4), 32'd0);
      step(); #2;
      chk("t4_addr_align", mem_addr4, 32'h40);
      chk("t4_half",       32'(mem_half4), 32'd0);
      chk("t4_byte",       32'(mem_byte4), 32'd0);
      chk("t4_read",       32'(mem_mr4), 32'd1);
      step(); #2;
      chk("t4_ack",   32'(dbg_ack4), 32'd1);
      chk("t4_rdata", dbg_rdata4, 32'hDEADBEEF);
      dbg_req = 1'b0; cpu_half = 1'b0; cpu_byte = 1'b0;

      // 4b: reset during the DBG slot aborts the write and the ack
      step(); dbg_req = 1'b1; dbg_write = 1'b1; dbg_address = 32'h48;
      dbg_wdata = 32'h12345678; #2;
      step(); rst_n = 1'b0; #2;
      chk("t4b_rst_write", 32'(mem_mw4), 32'd0);
      chk("t4b_rst_stall", 32'(cpu_stall4), 32'd0);
      step(); rst_n = 1'b1; #2;
      chk("t4b_no_ack",    32'(dbg_ack4), 32'd0);
      chk("t4b_rdata_clr", dbg_rdata4, 32'h0);
      step(); #2;
      chk("t4b_retry_write", 32'(mem_mw4), 32'd1);
      step(); #2;
      chk("t4b_retry_ack", 32'(dbg_ack4), 32'd1);
      dbg_req = 1'b0;
      step(); cpu_mr = 1'b1; cpu_address = 32'h48; #2;
      chk("t4b_cpu_lw", cpu_rdata4, 32'h12345678);

      // 5: MAX_WAIT=0 instance; SB 0xAA @0x41 as DBG read @0x40 rises
      step(); rst_n = 1'b0; cpu_mr = 1'b0; #2;
      step(); rst_n = 1'b1; #2;
      step(); cpu_mw = 1'b1; cpu_byte = 1'b1; cpu_address = 32'h41; cpu_wdata = 32'hAA;
      dbg_req = 1'b1; dbg_write = 1'b0; dbg_address = 32'h40; #2;
      chk("t5_sb_stall", 32'(cpu_stall0), 32'd0);
      chk("t5_sb_write", 32'(mem_mw0), 32'd1);
      chk("t5_sb_byte",  32'(mem_byte0), 32'd1);
      step(); cpu_mw = 1'b0; cpu_byte = 1'b0; cpu_mr = 1'b1; cpu_address = 32'h40; #2;
      chk("t5_dbg_stall", 32'(cpu_stall0), 32'd1);
      chk("t5_dbg_nowr",  32'(mem_mw0), 32'd0);
      chk("t5_dbg_byte",  32'(mem_byte0), 32'd0);
      step(); #2;
      chk("t5_ack",       32'(dbg_ack0), 32'd1);
      chk("t5_dbg_rdata", dbg_rdata0, 32'hDEADAAEF);
      chk("t5_lw_stall",  32'(cpu_stall0), 32'd0);
      chk("t5_lw_rdata",  cpu_rdata0, 32'hDEADAAEF);
      dbg_req = 1'b0; cpu_mr = 1'b0;

`ifdef DMEM_ARB_STATS_EN
      // 6: three conflicting grants plus two idle grants on MAX_WAIT=4
      step(); rst_n = 1'b0; #2;
      step(); rst_n = 1'b1; #2;
      chk("t6_stat_rst4", 32'(stat4), 32'd0);
      chk("t6_stat_rst0", 32'(stat0), 32'd0);
      for (int g = 0; g < 3; g++) begin
         step(); cpu_mr = 1'b1; cpu_address = 32'h44; dbg_req = 1'b1; #2;
         repeat (6) step();
         #2;
         chk("t6_conflict_ack", 32'(dbg_ack4), 32'd1);
         dbg_req = 1'b0;
      end
      for (int g = 0; g < 2; g++) begin
         step(); cpu_mr = 1'b0; dbg_req = 1'b1; #2;
         repeat (2) step();
         #2;
         chk("t6_idle_ack", 32'(dbg_ack4), 32'd1);
         dbg_req = 1'b0;
      end
      step(); #2;
      chk("t6_stat_count", 32'(stat4), 32'd3);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
